score_timer: RTL and testbench
==============================

SCORE_TIMER -- requirements
Module: score_timer

Interface
REQ-001 SHALL have parameter: TICKS_PER_POINT, default 1, number of tick strobes per score increment (legal range 1..255).
REQ-002 SHALL have port: clock  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port: tick  input  1  one-cycle strobe from the upstream 1 Hz divider.
REQ-005 SHALL have port: start  input  1  level, sampled each cycle; begins a game.
REQ-006 SHALL have port: pause  input  1  level; suspends counting while high.
REQ-007 SHALL have port: crash  input  1  level, sampled each cycle; ends the game.
REQ-008 SHALL have port: score  output  16  four BCD digits: [15:12] thousands, [3:0] units.
REQ-009 SHALL have port: running  output  1  high in RUN state.
REQ-010 SHALL have port: game_over  output  1  high in OVER state.
REQ-011 SHALL have port: saturated  output  1  high while score = 9999.
REQ-012 SHALL have port: high_score  output  16  BCD best score (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE, OVER; all outputs registered.
REQ-014 IDLE: score held 0000; start=1 -> RUN next cycle.
REQ-015 RUN: priority crash > pause > tick; crash=1 -> OVER; else pause=1 -> PAUSE; else tick counted.
REQ-016 PAUSE: crash=1 -> OVER; else pause=0 -> RUN; ticks in PAUSE ignored, prescaler held.
REQ-017 OVER: score frozen; start=1 -> RUN with score and prescaler cleared to 0 on the same edge.
REQ-018 Counted tick: 8-bit prescaler increments; when prescaler = TICKS_PER_POINT-1, prescaler -> 0 and score += 1 (BCD).
REQ-019 BCD increment SHALL ripple: digit 9 -> 0 with carry into next digit; no digit ever holds A-F.
REQ-020 At score 9999, further counted ticks SHALL leave score at 9999 (no wrap); saturated=1.
REQ-021 Latency: score reflects a counted tick on the clock edge immediately after the tick cycle.
REQ-022 tick coincident with crash or pause in RUN SHALL NOT be counted.
REQ-023 tick in the same cycle start is accepted (IDLE or OVER) SHALL NOT be counted.
REQ-024 start while in RUN or PAUSE SHALL be ignored.
REQ-025 running = (state==RUN); game_over = (state==OVER); both mutually exclusive.

Reset
REQ-026 reset=0 SHALL immediately force state IDLE, score 0000, prescaler 0, running 0, game_over 0, saturated 0, high_score 0000.
REQ-027 reset asserted mid-game SHALL discard the game; after release block waits in IDLE for start.
REQ-028 First counted tick possible no earlier than second rising edge after reset release.

Configuration
REQ-029 Macro SCORE_HIGH_EN defined: high_score register updated on the cycle after entering OVER if score > high_score (BCD compare, thousands first); retained across games until reset.
REQ-030 SCORE_HIGH_EN undefined: no high-score register is built; high_score tied to 16'h0000.

Verification
REQ-031 Reset release, start=1 one cycle, 12 ticks spaced 5 cycles -> running=1, score=0x0012 one cycle after last tick.
REQ-032 Preload to 0x0099 via 99 ticks, one more tick -> score=0x0100; at 0x9999 extra tick -> score stays 0x9999, saturated=1.
REQ-033 RUN at 0x0007, tick and crash in same cycle -> game_over=1, running=0, score=0x0007; further ticks no change.
REQ-034 RUN, pause=1 for 3 ticks then pause=0, 2 ticks -> score increases by exactly 2; TICKS_PER_POINT=3 with 7 ticks -> score=0x0002.
REQ-035 SCORE_HIGH_EN: game 1 ends at 0x0025, game 2 ends at 0x0010 -> high_score=0x0025; game 3 ends at 0x0031 -> 0x0031; without macro high_score=0x0000 throughout.
REQ-036 reset pulsed low mid-RUN at score 0x0040 (asynchronously, between edges) -> score=0x0000, state IDLE, high_score=0x0000 immediately.

Source files
------------

// File: rtl/score_timer.sv
// Game score timer: BCD score driven by tick strobes, IDLE/RUN/PAUSE/OVER FSM.
// Optional best-score register enabled by defining SCORE_HIGH_EN.
module score_timer #(
    parameter int TICKS_PER_POINT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic        pause,
    input  logic        crash,
    output logic [15:0] score,
    output logic        running,
    output logic        game_over,
    output logic        saturated,
    output logic [15:0] high_score
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [7:0] LP_TOP = 8'(TICKS_PER_POINT - 1);
    localparam logic [15:0] LP_MAX = 16'h9999;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_score;
    logic [15:0] w_score_d;
    logic [7:0]  r_presc;
    logic [7:0]  w_presc_d;
    logic        r_running;
    logic        r_over;
    logic        r_sat;
    logic        w_cnt;
    logic        w_clr;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state plus next score/prescaler; crash beats pause beats tick
    always_comb begin
        w_next    = r_state;
        w_cnt     = 1'b0;
        w_clr     = 1'b0;
        w_score_d = r_score;
        w_presc_d = r_presc;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = RUN;
                    w_clr  = 1'b1;
                end
            end
            RUN: begin
                if (crash)      w_next = OVER;
                else if (pause) w_next = PAUSE;
                else            w_cnt  = tick;
            end
            PAUSE: begin
                if (crash)       w_next = OVER;
                else if (!pause) w_next = RUN;
            end
            OVER: begin
                if (start) begin
                    w_next = RUN;
                    w_clr  = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
        if (w_clr) begin
            w_score_d = 16'h0000;
            w_presc_d = 8'd0;
        end else if (w_cnt) begin
            if (r_presc == LP_TOP) begin
                w_presc_d = 8'd0;
                if (r_score != LP_MAX) w_score_d = bcd_inc(r_score);
            end else begin
                w_presc_d = r_presc + 8'd1;
            end
        end
    end

    // Score, prescaler and registered status flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_score   <= 16'h0000;
            r_presc   <= 8'd0;
            r_running <= 1'b0;
            r_over    <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            r_score   <= w_score_d;
            r_presc   <= w_presc_d;
            r_running <= (w_next == RUN);
            r_over    <= (w_next == OVER);
            r_sat     <= (w_score_d == LP_MAX);
        end
    end

`ifdef SCORE_HIGH_EN
    logic [15:0] r_high;

    // Capture best score once the game has settled in OVER
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_high <= 16'h0000;
        end else if (r_state == OVER && r_score > r_high) begin
            r_high <= r_score;
        end
    end

    assign high_score = r_high;
`else
    assign high_score = 16'h0000;
`endif

    assign score     = r_score;
    assign running   = r_running;
    assign game_over = r_over;
    assign saturated = r_sat;

endmodule

// File: tb/tb_score_timer.sv
// Directed bench for score_timer: TICKS_PER_POINT=1 and =3 instances.
// Expected high_score follows SCORE_HIGH_EN.
module tb_score_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        crash = 1'b0;
    logic [15:0] score1, score3, hs1, hs3;
    logic        run1, run3, ovr1, ovr3, sat1, sat3;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef SCORE_HIGH_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    always #5 clk = ~clk;

    score_timer #(.TICKS_PER_POINT(1)) dut1 (
        .clock(clk), .reset(rst_n), .tick(tick), .start(start),
        .pause(pause), .crash(crash), .score(score1), .running(run1),
        .game_over(ovr1), .saturated(sat1), .high_score(hs1)
    );

    score_timer #(.TICKS_PER_POINT(3)) dut3 (
        .clock(clk), .reset(rst_n), .tick(tick), .start(start),
        .pause(pause), .crash(crash), .score(score3), .running(run3),
        .game_over(ovr3), .saturated(sat3), .high_score(hs3)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick_once();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_once();
    endtask

    // start accepted with a coincident tick that must not count
    task automatic begin_game();
        start = 1'b1;
        tick  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick  = 1'b0;
        check("start_score", score1, 16'h0000);
        check("start_run", {15'd0, run1}, 16'd1);
        check("start_over", {15'd0, ovr1}, 16'd0);
    endtask

    task automatic end_game(input logic with_tick);
        crash = 1'b1;
        tick  = with_tick;
        @(negedge clk);
        crash = 1'b0;
        tick  = 1'b0;
        @(negedge clk);
        check("end_over", {15'd0, ovr1}, 16'd1);
        check("end_run", {15'd0, run1}, 16'd0);
    endtask

    initial begin
        #1;
        check("rst_score", score1, 16'h0000);
        check("rst_run", {15'd0, run1}, 16'd0);
        check("rst_over", {15'd0, ovr1}, 16'd0);
        check("rst_sat", {15'd0, sat1}, 16'd0);
        check("rst_high", hs1, 16'h0000);

        @(negedge clk);
        ticks(1);
        check("idle_hold", score1, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Game 1: prescaler behaviour and the 12-tick run
        begin_game();
        ticks(7);
        check("tpp3_7", score3, 16'h0002);
        check("tpp1_7", score1, 16'h0007);
        ticks(5);
        check("g1_12", score1, 16'h0012);
        check("tpp3_12", score3, 16'h0004);
        check("g1_run", {15'd0, run1}, 16'd1);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ign", score1, 16'h0012);
        check("start_ign_run", {15'd0, run1}, 16'd1);

        pause = 1'b1;
        tick  = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("pause_tick", score1, 16'h0012);
        check("pause_run", {15'd0, run1}, 16'd0);
        ticks(3);
        check("pause_hold", score1, 16'h0012);
        pause = 1'b0;
        @(negedge clk);
        check("resume_run", {15'd0, run1}, 16'd1);
        ticks(2);
        check("resume_2", score1, 16'h0014);

        ticks(11);
        end_game(1'b1);
        check("g1_end", score1, 16'h0025);
        ticks(2);
        check("g1_frozen", score1, 16'h0025);
        check("g1_high", hs1, HS ? 16'h0025 : 16'h0000);

        // Game 2: tick coincident with crash at 0007
        begin_game();
        ticks(7);
        end_game(1'b1);
        check("g2_end", score1, 16'h0007);
        ticks(2);
        check("g2_frozen", score1, 16'h0007);
        check("g2_high", hs1, HS ? 16'h0025 : 16'h0000);

        // Game 3 lower than best, game 4 higher
        begin_game();
        ticks(10);
        end_game(1'b0);
        check("g3_end", score1, 16'h0010);
        check("g3_high", hs1, HS ? 16'h0025 : 16'h0000);

        begin_game();
        ticks(31);
        end_game(1'b0);
        check("g4_end", score1, 16'h0031);
        check("g4_high", hs1, HS ? 16'h0031 : 16'h0000);

        // Game 5: BCD ripple and saturation
        begin_game();
        ticks(99);
        check("bcd_99", score1, 16'h0099);
        ticks(1);
        check("bcd_100", score1, 16'h0100);
        tick = 1'b1;
        repeat (9898) @(negedge clk);
        tick = 1'b0;
        check("bcd_9998", score1, 16'h9998);
        check("sat_9998", {15'd0, sat1}, 16'd0);
        ticks(1);
        check("bcd_9999", score1, 16'h9999);
        check("sat_9999", {15'd0, sat1}, 16'd1);
        ticks(1);
        check("sat_hold", score1, 16'h9999);
        check("sat_flag", {15'd0, sat1}, 16'd1);
        end_game(1'b0);

        // Game 6: asynchronous reset mid-run
        begin_game();
        check("sat_clr", {15'd0, sat1}, 16'd0);
        ticks(40);
        check("g6_40", score1, 16'h0040);
        #2 rst_n = 1'b0;
        #1;
        check("arst_score", score1, 16'h0000);
        check("arst_run", {15'd0, run1}, 16'd0);
        check("arst_over", {15'd0, ovr1}, 16'd0);
        check("arst_high", hs1, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(2);
        check("post_idle", score1, 16'h0000);
        check("post_run", {15'd0, run1}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
